// File: rtl/mem_mon_pkg.sv
// Shared types and default constants for the data-memory write monitor.
package mem_mon_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } mon_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } log_entry_t;

  localparam int unsigned ENTRY_W = $bits(log_entry_t);

  localparam logic [31:0] DEF_PASS_ADDR    = 32'd84;
  localparam logic [31:0] DEF_PASS_DATA    = 32'd7;
  localparam logic [31:0] DEF_SCRATCH_ADDR = 32'd80;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; extra pointer bit separates full from empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // A pop frees the head slot on the same edge, so a full FIFO still accepts a push then.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/mem_write_monitor.sv
// Judges program outcome from core stores (PASS/FAIL) and logs every store accepted in RUN.
module mem_write_monitor
  import mem_mon_pkg::*;
#(
  parameter logic [31:0] PASS_ADDR    = DEF_PASS_ADDR,
  parameter logic [31:0] PASS_DATA    = DEF_PASS_DATA,
  parameter logic [31:0] SCRATCH_ADDR = DEF_SCRATCH_ADDR,
  parameter int unsigned LOG_DEPTH    = 8,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memwrite,
  input  logic [31:0]      dataadr,
  input  logic [31:0]      writedata,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [31:0]      fail_addr,
  output logic [31:0]      fail_data,
  output logic [CNT_W-1:0] store_count,
  output logic             log_valid,
  input  logic             log_ready,
  output logic [31:0]      log_addr,
  output logic [31:0]      log_data,
  output logic             log_overflow
);

  mon_state_e state;
  mon_state_e state_nxt;
  logic       accept;
  logic       take_fail;
  logic       log_full;
  logic       log_empty;
  log_entry_t push_entry;
  log_entry_t head_entry;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Store classifier and next-state logic; only RUN reacts to stores
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    take_fail = 1'b0;
    if (state == ST_RUN && memwrite) begin
      accept = 1'b1;
      if (dataadr == PASS_ADDR && writedata == PASS_DATA) begin
        state_nxt = ST_PASS;
      end else if (dataadr == SCRATCH_ADDR) begin
        state_nxt = ST_RUN;
      end else begin
        state_nxt = ST_FAIL;
        take_fail = 1'b1;
      end
    end
  end

  // Verdict flags track the state register so done/pass/fail stay mutually consistent
  always_ff @(posedge clk) begin
    if (reset) begin
      done <= 1'b0;
      pass <= 1'b0;
      fail <= 1'b0;
    end else begin
      done <= (state_nxt != ST_RUN);
      pass <= (state_nxt == ST_PASS);
      fail <= (state_nxt == ST_FAIL);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fail_addr <= '0;
      fail_data <= '0;
    end else if (take_fail) begin
      fail_addr <= dataadr;
      fail_data <= writedata;
    end
  end

  // Saturating store counter
  always_ff @(posedge clk) begin
    if (reset) begin
      store_count <= '0;
    end else if (accept && store_count != {CNT_W{1'b1}}) begin
      store_count <= store_count + CNT_W'(1);
    end
  end

  // A store is dropped only when the log is full and nothing leaves on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      log_overflow <= 1'b0;
    end else if (accept && log_full && !log_ready) begin
      log_overflow <= 1'b1;
    end
  end

  assign push_entry.addr = dataadr;
  assign push_entry.data = writedata;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (LOG_DEPTH)
  ) u_log (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (log_ready),
    .wdata (push_entry),
    .rdata (head_entry),
    .full  (log_full),
    .empty (log_empty)
  );

  assign log_valid = !log_empty;
  assign log_addr  = head_entry.addr;
  assign log_data  = head_entry.data;

endmodule

// File: tb/tb_mem_write_monitor.sv
// Scoreboard bench for mem_write_monitor: directed stores, queued log expectations.
module tb_mem_write_monitor;

  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             memwrite;
  logic [31:0]      dataadr;
  logic [31:0]      writedata;
  logic             done;
  logic             pass;
  logic             fail;
  logic [31:0]      fail_addr;
  logic [31:0]      fail_data;
  logic [CNT_W-1:0] store_count;
  logic             log_valid;
  logic             log_ready;
  logic [31:0]      log_addr;
  logic [31:0]      log_data;
  logic             log_overflow;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q [$];

  mem_write_monitor #(
    .PASS_ADDR    (32'd84),
    .PASS_DATA    (32'd7),
    .SCRATCH_ADDR (32'd80),
    .LOG_DEPTH    (8),
    .CNT_W        (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .memwrite     (memwrite),
    .dataadr      (dataadr),
    .writedata    (writedata),
    .done         (done),
    .pass         (pass),
    .fail         (fail),
    .fail_addr    (fail_addr),
    .fail_data    (fail_data),
    .store_count  (store_count),
    .log_valid    (log_valid),
    .log_ready    (log_ready),
    .log_addr     (log_addr),
    .log_data     (log_data),
    .log_overflow (log_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Log monitor: a handshake seen at negedge completes on the next rising edge
  always @(negedge clk) begin
    if (log_valid && log_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL log_unexpected: got %0h/%0h expected no entry", log_addr, log_data);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("log_addr", log_addr, e[63:32]);
        check("log_data", log_data, e[31:0]);
      end
    end
  end

  // All tasks start and end at posedge+1
  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input bit logged);
    memwrite  = 1'b1;
    dataadr   = a;
    writedata = d;
    if (logged) exp_q.push_back({a, d});
    @(posedge clk); #1;
    memwrite  = 1'b0;
  endtask

  task automatic drain();
    int n;
    log_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    log_ready = 1'b0;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d entries left expected 0", exp_q.size());
      exp_q.delete();
    end
    check("log_empty_after_drain", 32'(log_valid), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_done"},     32'(done), 32'd0);
    check({tag, "_pass"},     32'(pass), 32'd0);
    check({tag, "_fail"},     32'(fail), 32'd0);
    check({tag, "_fail_addr"}, fail_addr, 32'd0);
    check({tag, "_fail_data"}, fail_data, 32'd0);
    check({tag, "_count"},    32'(store_count), 32'd0);
    check({tag, "_log_valid"}, 32'(log_valid), 32'd0);
    check({tag, "_overflow"}, 32'(log_overflow), 32'd0);
  endtask

  initial begin
    reset = 1'b1; memwrite = 1'b0; dataadr = '0; writedata = '0; log_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    check_reset_state("rst");

    // Scratch stores then the passing store
    store(32'd80, 32'd1, 1'b1);
    check("scratch_no_verdict", 32'(done), 32'd0);
    check("log_valid_after_push", 32'(log_valid), 32'd1);
    store(32'd80, 32'd2, 1'b1);
    store(32'd84, 32'd7, 1'b1);
    check("pass", 32'(pass), 32'd1);
    check("pass_done", 32'(done), 32'd1);
    check("pass_nofail", 32'(fail), 32'd0);
    check("pass_count", 32'(store_count), 32'd3);
    store(32'd100, 32'd9, 1'b0);
    check("pass_terminal", 32'(pass), 32'd1);
    check("pass_terminal_count", 32'(store_count), 32'd3);
    drain();

    // Wrong data at the pass address
    do_reset();
    store(32'd84, 32'd6, 1'b1);
    check("wrongdata_fail", 32'(fail), 32'd1);
    check("wrongdata_done", 32'(done), 32'd1);
    check("wrongdata_pass", 32'(pass), 32'd0);
    check("wrongdata_addr", fail_addr, 32'd84);
    check("wrongdata_data", fail_data, 32'd6);
    store(32'd84, 32'd7, 1'b0);
    check("fail_terminal", 32'(fail), 32'd1);
    check("fail_terminal_pass", 32'(pass), 32'd0);
    check("fail_terminal_count", 32'(store_count), 32'd1);
    check("fail_terminal_data", fail_data, 32'd6);
    drain();

    // Illegal address
    do_reset();
    store(32'd100, 32'd5, 1'b1);
    check("badaddr_fail", 32'(fail), 32'd1);
    check("badaddr_addr", fail_addr, 32'd100);
    check("badaddr_data", fail_data, 32'd5);
    drain();

    // Overflow: nine stores with the consumer stalled, first eight kept
    do_reset();
    for (int i = 1; i <= 9; i++) store(32'd80, 32'(i), i <= 8);
    check("ovf_valid", 32'(log_valid), 32'd1);
    check("ovf_flag", 32'(log_overflow), 32'd1);
    check("ovf_count", 32'(store_count), 32'd9);
    drain();
    check("ovf_sticky", 32'(log_overflow), 32'd1);

    // Full log with a same-edge pop and push
    do_reset();
    for (int i = 0; i < 8; i++) store(32'd80, 32'h11 + 32'(i), 1'b1);
    log_ready = 1'b1;
    store(32'd80, 32'h19, 1'b1);
    log_ready = 1'b0;
    check("fullpop_overflow", 32'(log_overflow), 32'd0);
    check("fullpop_head", log_data, 32'h12);
    drain();

    // Reset mid-run with a non-empty log, and a store in the reset cycle
    do_reset();
    for (int i = 0; i < 3; i++) store(32'd80, 32'(i), 1'b1);
    memwrite = 1'b1; dataadr = 32'd84; writedata = 32'd7;
    do_reset();
    memwrite = 1'b0;
    check_reset_state("midrst");
    store(32'd84, 32'd7, 1'b1);
    check("postrst_pass", 32'(pass), 32'd1);
    check("postrst_count", 32'(store_count), 32'd1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
